lp_serializer_scheduler: RTL and testbench
==========================================

// Module: lp_serializer_scheduler
// PURPOSE
//  Shares one 16:1 tree serializer between NUM_REQ word sources. Round-robin grant
//  once per word slot (WORD_BITS CLK cycles); granted word held on PAR_OUT for the
//  whole slot. Emits slot/frame markers aligned to the serial stream. Sits between
//  requester FIFOs and the serializer PAR_IN, in the full-rate CLK domain.
// PARAMETERS
//  NUM_REQ      4        number of requesters (2..8)
//  WORD_BITS    16       bits per slot; must equal serializer INPUTS_NUM
//  SER_LATENCY  3        CLK cycles from PAR_OUT load to first bit at SERIAL_OUT
//  IDLE_WORD    16'hAAAA word driven in empty slots
// PORTS
//  CLK          in   1                  full-rate serial clock
//  RESET_N      in   1                  async assert, active-low reset
//  ENABLE       in   1                  1 = schedule slots; 0 = drain then idle
//  REQ_VALID    in   NUM_REQ            per-requester word available
//  REQ_DATA     in   NUM_REQ*WORD_BITS  packed words, requester i at [i*WORD_BITS +: WORD_BITS]
//  REQ_READY    out  NUM_REQ            one-hot accept pulse (1 cycle)
//  PAR_OUT      out  WORD_BITS          to serializer PAR_IN
//  SLOT_VALID   out  1                  current slot carries requester data
//  SLOT_OWNER   out  $clog2(NUM_REQ)    requester owning current slot
//  FRAME_SYNC   out  1                  pulse with first bit of each valid word at SERIAL_OUT
//  BUSY         out  1                  not in IDLE state
// BEHAVIOUR
//  Reset: PAR_OUT=IDLE_WORD, REQ_READY=0, SLOT_VALID=0, SLOT_OWNER=0, FRAME_SYNC=0,
//   BUSY=0, bit_cnt=0, rr pointer=0, FSM=IDLE, sync delay line cleared.
//  bit_cnt: 0..WORD_BITS-1, wraps; counts only in WARMUP/RUN/DRAIN, held at 0 in IDLE.
//  FSM: IDLE -(ENABLE)-> WARMUP; WARMUP holds IDLE_WORD for SER_LATENCY cycles -> RUN;
//   RUN -(!ENABLE at slot boundary)-> DRAIN; DRAIN finishes current slot + SER_LATENCY
//   cycles -> IDLE. ENABLE reasserted in DRAIN: go to RUN at next boundary.
//  Slot boundary = cycle with bit_cnt==WORD_BITS-1 in RUN. On it: arbiter picks first
//   valid requester at or after rr pointer; REQ_READY[g]=1 that cycle only (accept =
//   VALID&READY); next edge loads PAR_OUT<=REQ_DATA[g], SLOT_VALID<=1, SLOT_OWNER<=g,
//   rr pointer<=g+1 mod NUM_REQ. No valid requester: PAR_OUT<=IDLE_WORD,
//   SLOT_VALID<=0, pointer unchanged, no REQ_READY.
//  PAR_OUT/SLOT_* change only at slot loads; stable for exactly WORD_BITS cycles.
//  REQ_VALID drop mid-slot is ignored; sampled only at boundary cycle.
//  FRAME_SYNC = SLOT_VALID load pulse delayed SER_LATENCY cycles (shift register).
//  ENABLE drop mid-slot: slot completes unchanged; no further grants.
//  RESET_N mid-word: all outputs to reset values immediately; partial word lost.
// CONFIGURATION
//  LP_SER_SCHED_STATS_EN defined: adds outputs STAT_WORDS (NUM_REQ*16, saturating
//   per-requester grant counts) and STAT_IDLE (16, saturating empty-slot count),
//   input STAT_CLR (sync clear, priority over increment). Not defined: ports and
//   counters absent; scheduling behaviour identical.
// STRUCTURE
//  Package lp_ser_pkg: state_e {IDLE,WARMUP,RUN,DRAIN}, REQ_IDX_W, BIT_CNT_W
//   constants, default IDLE_WORD.
//  Sub-module lp_rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant + index.
// TESTING
//  1 Reset, ENABLE=1, no REQ_VALID -> PAR_OUT=16'hAAAA every slot, SLOT_VALID=0, REQ_READY=0.
//  2 REQ_VALID=4'b1111, data 16'h1111..16'h4444 -> owners 0,1,2,3,0; one READY pulse per slot at bit_cnt=15.
//  3 Only req2 valid with 16'hBEEF -> every slot owner 2; FRAME_SYNC SER_LATENCY(3) cycles after each load.
//  4 ENABLE drop at bit_cnt=5 -> current word held to cycle 15, then IDLE_WORD; BUSY low 3 cycles later.
//  5 RESET_N low at bit_cnt=8 -> outputs reset immediately; after release, WARMUP 3 cycles before first grant.
//  6 STATS_EN: 10 grants to req1 then STAT_CLR -> STAT_WORDS[1] reads 10, then 0; saturates at 16'hFFFF.

Source files
------------

// File: rtl/lp_ser_pkg.sv
// ----------------------------------------------------------------------------
// lp_ser_pkg
//   Shared types and constants for the serializer slot scheduler.
//   - state_e       : scheduler FSM states
//   - *_DEF         : default parameter values for the scheduler top
//   - REQ_IDX_W     : requester index width for the default requester count
//   - BIT_CNT_W     : bit counter width for the default word size
//   - sat_inc16()   : 16-bit saturating increment used by the statistics block
// ----------------------------------------------------------------------------
package lp_ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    localparam int          NUM_REQ_DEF     = 4;
    localparam int          WORD_BITS_DEF   = 16;
    localparam int          SER_LATENCY_DEF = 3;
    localparam int          REQ_IDX_W       = $clog2(NUM_REQ_DEF);
    localparam int          BIT_CNT_W       = $clog2(WORD_BITS_DEF);
    localparam logic [15:0] IDLE_WORD_DEF   = 16'hAAAA;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/lp_rr_arbiter.sv
// ----------------------------------------------------------------------------
// lp_rr_arbiter
//   Purely combinational round-robin pick: the first asserted request at or
//   after the pointer position, wrapping around NUM_REQ.
// Ports
//   req        in   NUM_REQ   request vector
//   ptr        in   IDX_W     highest-priority requester index
//   grant      out  NUM_REQ   one-hot grant (all zero when nothing requests)
//   grant_idx  out  IDX_W     index of the granted requester
//   grant_any  out  1         at least one request was granted
// ----------------------------------------------------------------------------
module lp_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    int cand;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/lp_serializer_scheduler.sv
// ----------------------------------------------------------------------------
// lp_serializer_scheduler
//   Time-shares one WORD_BITS:1 serializer between NUM_REQ word sources. One
//   round-robin grant per word slot; the granted word is held on PAR_OUT for
//   the whole slot and FRAME_SYNC marks its first bit at the serial output.
//
// Ports
//   CLK         in   1                  full-rate serial clock
//   RESET_N     in   1                  asynchronous active-low reset
//   ENABLE      in   1                  1 = schedule slots, 0 = drain then idle
//   REQ_VALID   in   NUM_REQ            per-requester word available
//   REQ_DATA    in   NUM_REQ*WORD_BITS  requester i at [i*WORD_BITS +: WORD_BITS]
//   REQ_READY   out  NUM_REQ            one-hot accept pulse at slot boundary
//   PAR_OUT     out  WORD_BITS          word to serializer PAR_IN
//   SLOT_VALID  out  1                  current slot carries requester data
//   SLOT_OWNER  out  $clog2(NUM_REQ)    requester owning the current slot
//   FRAME_SYNC  out  1                  first bit of a valid word at SERIAL_OUT
//   BUSY        out  1                  FSM not in IDLE
//
// Optional feature (macro LP_SER_SCHED_STATS_EN):
//   STAT_CLR    in   1                  synchronous clear, wins over increment
//   STAT_WORDS  out  NUM_REQ*16         saturating per-requester grant counts
//   STAT_IDLE   out  16                 saturating empty-slot count
// ----------------------------------------------------------------------------
module lp_serializer_scheduler
    import lp_ser_pkg::*;
#(
    parameter int                   NUM_REQ     = NUM_REQ_DEF,
    parameter int                   WORD_BITS   = WORD_BITS_DEF,
    parameter int                   SER_LATENCY = SER_LATENCY_DEF,
    parameter logic [WORD_BITS-1:0] IDLE_WORD   = WORD_BITS'(IDLE_WORD_DEF)
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic                           ENABLE,
    input  logic [NUM_REQ-1:0]             REQ_VALID,
    input  logic [NUM_REQ*WORD_BITS-1:0]   REQ_DATA,
    output logic [NUM_REQ-1:0]             REQ_READY,
    output logic [WORD_BITS-1:0]           PAR_OUT,
    output logic                           SLOT_VALID,
    output logic [$clog2(NUM_REQ)-1:0]     SLOT_OWNER,
    output logic                           FRAME_SYNC,
    output logic                           BUSY
`ifdef LP_SER_SCHED_STATS_EN
    ,
    input  logic                           STAT_CLR,
    output logic [NUM_REQ*16-1:0]          STAT_WORDS,
    output logic [15:0]                    STAT_IDLE
`endif
);

    localparam int              IDX_W    = $clog2(NUM_REQ);
    localparam int              CNT_W    = $clog2(WORD_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(SER_LATENCY - 1);

    state_e                 state_q;
    state_e                 state_d;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [SER_LATENCY:0]   sync_sr_q;      // [0] is the load pulse itself

    logic                   boundary;
    logic                   take;
    logic [NUM_REQ-1:0]     grant_oh;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [WORD_BITS-1:0]   grant_word;

    lp_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (REQ_VALID),
        .ptr       (rr_ptr_q),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Requests are only looked at on the last bit of a RUN slot; with ENABLE
    // low that boundary loads IDLE_WORD and hands over to DRAIN instead.
    assign boundary  = (state_q == RUN) && (bit_cnt_q == LAST_BIT);
    assign take      = boundary && ENABLE && grant_any;
    assign REQ_READY = take ? grant_oh : '0;
    assign BUSY      = (state_q != IDLE);
    assign FRAME_SYNC = sync_sr_q[SER_LATENCY];

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                grant_word = REQ_DATA[i*WORD_BITS +: WORD_BITS];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. WARMUP covers the serializer pipeline fill with the
    // idle pattern; DRAIN lets the last loaded word flush out of it.
    // Re-enabling during DRAIN resumes RUN on the running bit count, so the
    // next boundary grants again without another warm-up.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (ENABLE) state_d = WARMUP;
            WARMUP: if (bit_cnt_q == LAT_LAST) state_d = RUN;
            RUN:    if (boundary && !ENABLE) state_d = DRAIN;
            DRAIN: begin
                if (ENABLE) begin
                    state_d = RUN;
                end else if (bit_cnt_q == LAT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) || (state_d == IDLE) || (bit_cnt_q == LAST_BIT)) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
        end
    end

    // Slot registers: touched only on a boundary, so they stay stable for
    // exactly WORD_BITS cycles between loads.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PAR_OUT    <= IDLE_WORD;
            SLOT_VALID <= 1'b0;
            SLOT_OWNER <= '0;
            rr_ptr_q   <= '0;
        end else if (boundary) begin
            if (take) begin
                PAR_OUT    <= grant_word;
                SLOT_VALID <= 1'b1;
                SLOT_OWNER <= grant_idx;
                rr_ptr_q   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                 : grant_idx + IDX_W'(1);
            end else begin
                PAR_OUT    <= IDLE_WORD;
                SLOT_VALID <= 1'b0;
            end
        end
    end

    // The load pulse rides a SER_LATENCY-deep delay line so FRAME_SYNC lines
    // up with the first serial bit of the word rather than with PAR_OUT.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_sr_q <= '0;
        end else begin
            sync_sr_q <= {sync_sr_q[SER_LATENCY-1:0], take};
        end
    end

`ifdef LP_SER_SCHED_STATS_EN
    logic [15:0] stat_word_q [NUM_REQ];
    logic [15:0] stat_idle_q;

    // NOTE: the counter array is reset element by element; these are
    // flip-flops read on outputs, not a RAM, so they must start at zero.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_word_q[i] <= '0;
            end
            stat_idle_q <= '0;
        end else if (STAT_CLR) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_word_q[i] <= '0;
            end
            stat_idle_q <= '0;
        end else if (boundary) begin
            if (take) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_oh[i]) begin
                        stat_word_q[i] <= sat_inc16(stat_word_q[i]);
                    end
                end
            end else begin
                stat_idle_q <= sat_inc16(stat_idle_q);
            end
        end
    end

    always_comb begin
        STAT_WORDS = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            STAT_WORDS[i*16 +: 16] = stat_word_q[i];
        end
    end

    assign STAT_IDLE = stat_idle_q;
`endif

endmodule

// File: tb/tb_lp_serializer_scheduler.sv
// ----------------------------------------------------------------------------
// tb_lp_serializer_scheduler
//   Directed bench for lp_serializer_scheduler (default parameters). Inputs are
//   driven and outputs sampled on the falling clock edge. `cyc` counts rising
//   edges since reset release: with ENABLE high from release, the first slot
//   boundary is observed at cyc 16 and every 16 cycles after that.
//   Statistics checks are built only with LP_SER_SCHED_STATS_EN defined.
// ----------------------------------------------------------------------------
module tb_lp_serializer_scheduler;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        ENABLE;
    logic [3:0]  REQ_VALID;
    logic [63:0] REQ_DATA;
    logic [3:0]  REQ_READY;
    logic [15:0] PAR_OUT;
    logic        SLOT_VALID;
    logic [1:0]  SLOT_OWNER;
    logic        FRAME_SYNC;
    logic        BUSY;
`ifdef LP_SER_SCHED_STATS_EN
    logic        STAT_CLR;
    logic [63:0] STAT_WORDS;
    logic [15:0] STAT_IDLE;
`endif

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    logic [63:0] rr_data;

    lp_serializer_scheduler dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .ENABLE     (ENABLE),
        .REQ_VALID  (REQ_VALID),
        .REQ_DATA   (REQ_DATA),
        .REQ_READY  (REQ_READY),
        .PAR_OUT    (PAR_OUT),
        .SLOT_VALID (SLOT_VALID),
        .SLOT_OWNER (SLOT_OWNER),
        .FRAME_SYNC (FRAME_SYNC),
        .BUSY       (BUSY)
`ifdef LP_SER_SCHED_STATS_EN
        ,
        .STAT_CLR   (STAT_CLR),
        .STAT_WORDS (STAT_WORDS),
        .STAT_IDLE  (STAT_IDLE)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge CLK);
        cyc++;
    endtask

    task automatic apply_reset();
        RESET_N   = 1'b0;
        ENABLE    = 1'b0;
        REQ_VALID = '0;
        REQ_DATA  = '0;
`ifdef LP_SER_SCHED_STATS_EN
        STAT_CLR  = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        cyc     = 0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // Reset values, then a few disabled cycles that must stay idle.
    task automatic test_reset();
        RESET_N   = 1'b0;
        ENABLE    = 1'b0;
        REQ_VALID = 4'hF;
        REQ_DATA  = 64'h4444_3333_2222_1111;
`ifdef LP_SER_SCHED_STATS_EN
        STAT_CLR  = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        vectors++;
        if ({PAR_OUT, REQ_READY, SLOT_VALID, SLOT_OWNER, FRAME_SYNC, BUSY} !==
            {16'hAAAA, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: par=%h ready=%b sv=%b own=%0d fs=%b busy=%b, need par=aaaa ready=0000 sv=0 own=0 fs=0 busy=0",
                     PAR_OUT, REQ_READY, SLOT_VALID, SLOT_OWNER, FRAME_SYNC, BUSY);
        end
        RESET_N = 1'b1;
        cyc     = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if ({PAR_OUT, REQ_READY, BUSY} !== {16'hAAAA, 4'b0000, 1'b0}) begin
                errors++;
                $display("FAIL disabled_idle cyc=%0d: par=%h ready=%b busy=%b, need par=aaaa ready=0000 busy=0",
                         cyc, PAR_OUT, REQ_READY, BUSY);
            end
        end
    endtask

    // Enabled with no requests: idle word in every slot, no accepts.
    task automatic test_idle_slots();
        apply_reset();
        ENABLE = 1'b1;
        for (int i = 0; i < 48; i++) begin
            tick();
            vectors++;
            if ({PAR_OUT, SLOT_VALID, REQ_READY, FRAME_SYNC, BUSY} !==
                {16'hAAAA, 1'b0, 4'b0000, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL idle_slot cyc=%0d: par=%h sv=%b ready=%b fs=%b busy=%b, need par=aaaa sv=0 ready=0000 fs=0 busy=1",
                         cyc, PAR_OUT, SLOT_VALID, REQ_READY, FRAME_SYNC, BUSY);
            end
        end
    endtask

    // All four requesting: owners rotate 0,1,2,3,0 with one READY per slot.
    task automatic test_round_robin();
        int exp_owner [6] = '{0, 1, 2, 3, 0, 1};
        logic [3:0]  exp_ready;
        logic [15:0] exp_word;
        apply_reset();
        REQ_DATA  = rr_data;
        REQ_VALID = 4'hF;
        ENABLE    = 1'b1;
        run_to(16);
        vectors++;
        if (REQ_READY !== 4'b0001) begin
            errors++;
            $display("FAIL rr_first_ready: ready=%b, need 0001", REQ_READY);
        end
        for (int s = 0; s < 5; s++) begin
            exp_word = rr_data[exp_owner[s]*16 +: 16];
            for (int k = 0; k < 16; k++) begin
                tick();
                exp_ready = (k == 15) ? (4'b0001 << exp_owner[s+1]) : 4'b0000;
                vectors++;
                if ({PAR_OUT, SLOT_VALID, SLOT_OWNER, REQ_READY, FRAME_SYNC} !==
                    {exp_word, 1'b1, 2'(exp_owner[s]), exp_ready, (k == 3)}) begin
                    errors++;
                    $display("FAIL rr_slot s=%0d k=%0d: par=%h sv=%b own=%0d ready=%b fs=%b, need par=%h sv=1 own=%0d ready=%b fs=%b",
                             s, k, PAR_OUT, SLOT_VALID, SLOT_OWNER, REQ_READY, FRAME_SYNC,
                             exp_word, exp_owner[s], exp_ready, (k == 3));
                end
            end
        end
    endtask

    // Only requester 2: it owns every slot; FRAME_SYNC 3 cycles after load;
    // a mid-slot VALID drop is ignored.
    task automatic test_single_req();
        logic [3:0] exp_ready;
        apply_reset();
        REQ_DATA  = 64'h0404_BEEF_0202_0101;
        REQ_VALID = 4'b0100;
        ENABLE    = 1'b1;
        run_to(16);
        vectors++;
        if ({REQ_READY, FRAME_SYNC} !== {4'b0100, 1'b0}) begin
            errors++;
            $display("FAIL single_first_ready: ready=%b fs=%b, need ready=0100 fs=0", REQ_READY, FRAME_SYNC);
        end
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 16; k++) begin
                tick();
                exp_ready = (k == 15) ? 4'b0100 : 4'b0000;
                vectors++;
                if ({PAR_OUT, SLOT_VALID, SLOT_OWNER, REQ_READY, FRAME_SYNC} !==
                    {16'hBEEF, 1'b1, 2'd2, exp_ready, (k == 3)}) begin
                    errors++;
                    $display("FAIL single_slot s=%0d k=%0d: par=%h sv=%b own=%0d ready=%b fs=%b, need par=beef sv=1 own=2 ready=%b fs=%b",
                             s, k, PAR_OUT, SLOT_VALID, SLOT_OWNER, REQ_READY, FRAME_SYNC, exp_ready, (k == 3));
                end
                if (k == 5)  REQ_VALID = 4'b0000;
                if (k == 10) REQ_VALID = 4'b0100;
            end
        end
    endtask

    // ENABLE drops at bit 5: word held to bit 15, then idle word, BUSY low
    // three cycles after that.
    task automatic test_enable_drop();
        apply_reset();
        REQ_DATA  = rr_data;
        REQ_VALID = 4'hF;
        ENABLE    = 1'b1;
        run_to(16);
        for (int k = 0; k < 16; k++) begin
            tick();
            vectors++;
            if ({PAR_OUT, SLOT_VALID, SLOT_OWNER, REQ_READY, BUSY} !==
                {16'h1111, 1'b1, 2'd0, 4'b0000, 1'b1}) begin
                errors++;
                $display("FAIL drop_hold k=%0d: par=%h sv=%b own=%0d ready=%b busy=%b, need par=1111 sv=1 own=0 ready=0000 busy=1",
                         k, PAR_OUT, SLOT_VALID, SLOT_OWNER, REQ_READY, BUSY);
            end
            if (k == 5) ENABLE = 1'b0;
        end
        for (int j = 0; j < 24; j++) begin
            tick();
            vectors++;
            if ({PAR_OUT, SLOT_VALID, REQ_READY, BUSY} !==
                {16'hAAAA, 1'b0, 4'b0000, (j < 3)}) begin
                errors++;
                $display("FAIL drop_drain j=%0d: par=%h sv=%b ready=%b busy=%b, need par=aaaa sv=0 ready=0000 busy=%b",
                         j, PAR_OUT, SLOT_VALID, REQ_READY, BUSY, (j < 3));
            end
        end
    endtask

    // Reset at bit 8 of a slot owned by req0 (pointer then at 1): outputs
    // clear at once; after release the first grant goes to req0 again.
    task automatic test_reset_midword();
        apply_reset();
        REQ_DATA  = rr_data;
        REQ_VALID = 4'hF;
        ENABLE    = 1'b1;
        run_to(25);
        vectors++;
        if (PAR_OUT !== 16'h1111) begin
            errors++;
            $display("FAIL midword_pre: par=%h, need 1111", PAR_OUT);
        end
        RESET_N = 1'b0;
        #1;
        vectors++;
        if ({PAR_OUT, REQ_READY, SLOT_VALID, SLOT_OWNER, FRAME_SYNC, BUSY} !==
            {16'hAAAA, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midword_reset: par=%h ready=%b sv=%b own=%0d fs=%b busy=%b, need par=aaaa ready=0000 sv=0 own=0 fs=0 busy=0",
                     PAR_OUT, REQ_READY, SLOT_VALID, SLOT_OWNER, FRAME_SYNC, BUSY);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        cyc     = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            vectors++;
            if ({PAR_OUT, SLOT_VALID, REQ_READY, BUSY} !== {16'hAAAA, 1'b0, 4'b0000, 1'b1}) begin
                errors++;
                $display("FAIL midword_warmup cyc=%0d: par=%h sv=%b ready=%b busy=%b, need par=aaaa sv=0 ready=0000 busy=1",
                         cyc, PAR_OUT, SLOT_VALID, REQ_READY, BUSY);
            end
        end
        tick();
        vectors++;
        if (REQ_READY !== 4'b0001) begin
            errors++;
            $display("FAIL midword_first_grant: ready=%b, need 0001", REQ_READY);
        end
        tick();
        vectors++;
        if ({PAR_OUT, SLOT_VALID, SLOT_OWNER} !== {16'h1111, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL midword_first_load: par=%h sv=%b own=%0d, need par=1111 sv=1 own=0",
                     PAR_OUT, SLOT_VALID, SLOT_OWNER);
        end
    endtask

`ifdef LP_SER_SCHED_STATS_EN
    // Ten grants to req1, clear, one more grant, then one empty slot.
    task automatic test_stats();
        apply_reset();
        REQ_DATA  = 64'h0000_0000_5A5A_0000;
        REQ_VALID = 4'b0010;
        ENABLE    = 1'b1;
        run_to(163);
        vectors++;
        if ({STAT_WORDS, STAT_IDLE} !== {64'h0000_0000_000A_0000, 16'h0000}) begin
            errors++;
            $display("FAIL stats_ten: words=%h idle=%h, need words=00000000000a0000 idle=0000",
                     STAT_WORDS, STAT_IDLE);
        end
        STAT_CLR = 1'b1;
        tick();
        STAT_CLR = 1'b0;
        vectors++;
        if ({STAT_WORDS, STAT_IDLE} !== {64'h0, 16'h0}) begin
            errors++;
            $display("FAIL stats_clear: words=%h idle=%h, need all zero", STAT_WORDS, STAT_IDLE);
        end
        run_to(178);
        REQ_VALID = 4'b0000;
        vectors++;
        if (STAT_WORDS !== 64'h0000_0000_0001_0000) begin
            errors++;
            $display("FAIL stats_after_clear: words=%h, need 0000000000010000", STAT_WORDS);
        end
        run_to(194);
        vectors++;
        if ({STAT_WORDS, STAT_IDLE} !== {64'h0000_0000_0001_0000, 16'h0001}) begin
            errors++;
            $display("FAIL stats_idle: words=%h idle=%h, need words=0000000000010000 idle=0001",
                     STAT_WORDS, STAT_IDLE);
        end
    endtask
`endif

    initial begin
        rr_data = 64'h4444_3333_2222_1111;
        test_reset();
        test_idle_slots();
        test_round_robin();
        test_single_req();
        test_enable_drop();
        test_reset_midword();
`ifdef LP_SER_SCHED_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
